// File: rtl/riscv_pkg.sv
// Shared RV64 core types and constants used by the fetch stage.
package riscv_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;

    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD
    } fetch_state_t;

    // PC/instruction pair handed to the IF/ID buffer
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } if_payload_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response handshake between fetch and imem.
interface fetch_unit_if;

    logic                           imem_req;
    logic [riscv_pkg::XLEN-1:0]     imem_addr;
    logic                           imem_ready;
    logic                           imem_rvalid;
    logic [riscv_pkg::ILEN-1:0]     imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_pc_reg.sv
// Fetch PC register with redirect / +4 / hold next-PC selection.
module fetch_pc_reg
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            advance,
    output logic [XLEN-1:0] pc_q
);

    logic [XLEN-1:0] pc_d;

    // Redirect wins; low two bits are dropped since there is no C extension
    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc & ~XLEN'(3);
        end else if (advance) begin
            pc_d = pc_q + XLEN'(4);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches from imem and feeds IF/ID,
// handling downstream stall, redirect flush and stale-response discard.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 64'h0
) (
    input  logic              clk,
    input  logic              rst_n,
    fetch_unit_if.master      imem,
    input  logic              id_stall,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              if_valid,
    output logic [ILEN-1:0]   if_instr,
    output logic [XLEN-1:0]   if_pc
);

    fetch_state_t state_q, state_d;
    logic         discard_q, discard_d;
    logic         req_q;
    logic         valid_q, valid_d;
    if_payload_t  out_q, out_d;
    logic         advance;
    logic         issue_c;
    logic         xfer_c;
    logic [XLEN-1:0] pc_q;

    assign issue_c = req_q && imem.imem_ready;
    assign xfer_c  = valid_q && !id_stall;

    fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .advance        (advance),
        .pc_q           (pc_q)
    );

    always_comb begin
        state_d   = state_q;
        discard_d = discard_q;
        valid_d   = valid_q;
        out_d     = out_q;
        advance   = 1'b0;

        unique case (state_q)
            S_REQ: begin
                if (issue_c) begin
                    state_d   = S_WAIT;
                    discard_d = redirect_valid;
                end
            end
            S_WAIT: begin
                if (imem.imem_rvalid) begin
                    discard_d = 1'b0;
                    if (redirect_valid || discard_q) begin
                        state_d = S_REQ;
                    end else if (valid_q && id_stall) begin
                        // Output still occupied: drop the word, refetch this PC after transfer
                        state_d = S_HOLD;
                    end else begin
                        state_d   = S_REQ;
                        advance   = 1'b1;
                        valid_d   = 1'b1;
                        out_d.pc  = pc_q;
                        out_d.instr = imem.imem_rdata;
                    end
                end else if (redirect_valid) begin
                    discard_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect_valid || xfer_c) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase

        if (redirect_valid || (!advance && xfer_c)) begin
            valid_d     = 1'b0;
            out_d.instr = NOP_INSTR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_REQ;
            discard_q <= 1'b0;
            req_q     <= 1'b0;
            valid_q   <= 1'b0;
            out_q     <= '{pc: '0, instr: NOP_INSTR};
        end else begin
            state_q   <= state_d;
            discard_q <= discard_d;
            req_q     <= (state_d == S_REQ);
            valid_q   <= valid_d;
            out_q     <= out_d;
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc_q;
    assign if_valid       = valid_q;
    assign if_instr       = out_q.instr;
    assign if_pc          = out_q.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: transaction-level model plus directed literal checks.
module tb_fetch_unit;
    import riscv_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, rst1_n;
    logic        id_stall, redirect_valid;
    logic [63:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [63:0] if_pc;

    logic        stall1, redir1;
    logic [63:0] rpc1;
    logic        if_valid1;
    logic [31:0] if_instr1;
    logic [63:0] if_pc1;

    fetch_unit_if imem();
    fetch_unit_if imem1();

    fetch_unit #(.RESET_PC(64'h1000)) dut (
        .clk(clk), .rst_n(rst_n), .imem(imem),
        .id_stall(id_stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc)
    );

    fetch_unit #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut1 (
        .clk(clk), .rst_n(rst1_n), .imem(imem1),
        .id_stall(stall1), .redirect_valid(redir1), .redirect_pc(rpc1),
        .if_valid(if_valid1), .if_instr(if_instr1), .if_pc(if_pc1)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: outstanding fetches, architectural PC, IF/ID slot
    typedef struct {
        logic [63:0] addr;
        logic        stale;
    } fetch_t;

    fetch_t      m_q[$];
    logic [63:0] m_pc;
    logic        m_started, m_hold, m_valid;
    logic [31:0] m_instr;
    logic [63:0] m_ifpc;

    function automatic logic model_req();
        return m_started && (m_q.size() == 0) && !m_hold;
    endfunction

    task automatic model_update(input logic iss, input logic rv, input logic [31:0] rdat,
                                input logic stl, input logic rd, input logic [63:0] rpc);
        fetch_t e;
        logic   xfer;
        logic   useful;
        xfer   = m_valid && !stl;
        useful = 1'b0;
        e      = '{addr: 64'h0, stale: 1'b1};
        if (rv && m_q.size() > 0) begin
            e = m_q.pop_front();
            if (!e.stale && !rd) begin
                if (m_valid && stl) m_hold = 1'b1;
                else                useful = 1'b1;
            end
        end
        if (rd) foreach (m_q[i]) m_q[i].stale = 1'b1;
        if (iss) m_q.push_back('{addr: m_pc, stale: rd});
        if (rd) begin
            m_pc    = {rpc[63:2], 2'b00};
            m_valid = 1'b0;
            m_instr = 32'h0000_0013;
            m_hold  = 1'b0;
        end else if (useful) begin
            m_valid = 1'b1;
            m_instr = rdat;
            m_ifpc  = e.addr;
            m_pc    = m_pc + 64'd4;
        end else if (xfer) begin
            m_valid = 1'b0;
            m_instr = 32'h0000_0013;
            m_hold  = 1'b0;
        end
        m_started = 1'b1;
    endtask

    // Bench memory: one response per issue, after mem_lat extra cycles
    logic        ready_en = 1'b1;
    logic        ov_en    = 1'b0;
    logic [31:0] ov_data  = 32'h0;
    int          mem_lat  = 0;
    logic        mem_busy = 1'b0;
    int          mem_cnt  = 0;
    logic [63:0] mem_addr = 64'h0;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a == 64'h1000) return 32'h0050_0093;
        return a[31:0] ^ 32'hA5A5_0000;
    endfunction

    task automatic step(input logic stl, input logic rd, input logic [63:0] rpc);
        logic        rv;
        logic        iss;
        logic [31:0] rdat;
        id_stall        = stl;
        redirect_valid  = rd;
        redirect_pc     = rpc;
        imem.imem_ready = ready_en;
        rv   = mem_busy && (mem_cnt == 0);
        rdat = ov_en ? ov_data : mem_word(mem_addr);
        imem.imem_rvalid = rv;
        imem.imem_rdata  = rv ? rdat : 32'h0;
        iss = model_req() && ready_en;
        if (rv) mem_busy = 1'b0;
        else if (mem_busy) mem_cnt--;
        if (iss) begin
            mem_busy = 1'b1;
            mem_addr = m_pc;
            mem_cnt  = mem_lat;
        end
        @(posedge clk);
        #1;
        model_update(iss, rv, rdat, stl, rd, rpc);
        imem.imem_rvalid = 1'b0;
        redirect_valid   = 1'b0;
    endtask

    logic chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_req",    64'(imem.imem_req), 64'(model_req()));
            chk("model_addr",   imem.imem_addr,     m_pc);
            chk("model_valid",  64'(if_valid),      64'(m_valid));
            chk("model_instr",  64'(if_instr),      64'(m_instr));
            chk("model_if_pc",  if_pc,              m_ifpc);
        end
    end

    initial begin
        m_pc = 64'h1000; m_started = 1'b0; m_hold = 1'b0; m_valid = 1'b0;
        m_instr = 32'h0000_0013; m_ifpc = 64'h0;
        id_stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 64'h0;
        imem.imem_ready = 1'b1; imem.imem_rvalid = 1'b0; imem.imem_rdata = 32'h0;
        imem1.imem_ready = 1'b1; imem1.imem_rvalid = 1'b0; imem1.imem_rdata = 32'h0;
        stall1 = 1'b0; redir1 = 1'b0; rpc1 = 64'h0;
        rst_n = 1'b1; rst1_n = 1'b1;
        #1;
        rst_n = 1'b0; rst1_n = 1'b0;
        #1;
        chk("rst_req",    64'(imem.imem_req), 64'h0);
        chk("rst_addr",   imem.imem_addr,     64'h1000);
        chk("rst_valid",  64'(if_valid),      64'h0);
        chk("rst_instr",  64'(if_instr),      64'h13);
        chk("rst_if_pc",  if_pc,              64'h0);
        chk("rst1_addr",  imem1.imem_addr,    64'hFFFF_FFFF_FFFF_FFFC);
        chk("rst1_req",   64'(imem1.imem_req), 64'h0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // First fetch with zero-wait memory
        step(0, 0, 0);
        chk("first_req",  64'(imem.imem_req), 64'h1);
        chk("first_addr", imem.imem_addr,     64'h1000);
        step(0, 0, 0);
        step(0, 0, 0);
        chk("first_valid", 64'(if_valid), 64'h1);
        chk("first_if_pc", if_pc,         64'h1000);
        chk("first_instr", 64'(if_instr), 64'h0050_0093);
        chk("next_addr",   imem.imem_addr, 64'h1004);

        // Memory not ready for three cycles
        ready_en = 1'b0;
        repeat (3) begin
            step(0, 0, 0);
            chk("nrdy_req",   64'(imem.imem_req), 64'h1);
            chk("nrdy_addr",  imem.imem_addr,     64'h1004);
            chk("nrdy_valid", 64'(if_valid),      64'h0);
        end
        ready_en = 1'b1;
        step(0, 0, 0);
        chk("nrdy_issued", 64'(imem.imem_req), 64'h0);
        step(0, 0, 0);
        chk("f2_if_pc", if_pc,          64'h1004);
        chk("f2_instr", 64'(if_instr),  64'hA5A5_1004);

        // Downstream stall with valid output
        repeat (4) begin
            step(1, 0, 0);
            chk("stall_if_pc", if_pc,          64'h1004);
            chk("stall_instr", 64'(if_instr),  64'hA5A5_1004);
        end
        chk("stall_req", 64'(imem.imem_req), 64'h0);
        step(0, 0, 0);
        chk("unstall_req",   64'(imem.imem_req), 64'h1);
        chk("unstall_addr",  imem.imem_addr,     64'h1008);
        chk("unstall_valid", 64'(if_valid),      64'h0);
        step(0, 0, 0);
        step(0, 0, 0);
        chk("f3_if_pc", if_pc, 64'h1008);

        // Redirect coinciding with a response in S_WAIT
        step(0, 0, 0);
        ov_en = 1'b1; ov_data = 32'hDEAD_BEEF;
        step(0, 1, 64'h2002);
        ov_en = 1'b0;
        chk("rdw_valid", 64'(if_valid),      64'h0);
        chk("rdw_instr", 64'(if_instr),      64'h13);
        chk("rdw_addr",  imem.imem_addr,     64'h2000);
        chk("rdw_req",   64'(imem.imem_req), 64'h1);
        step(0, 0, 0);
        step(0, 0, 0);
        chk("f4_if_pc", if_pc,         64'h2000);
        chk("f4_instr", 64'(if_instr), 64'hA5A5_2000);

        // Redirect in the same cycle as an issue
        ready_en = 1'b0;
        step(0, 1, 64'h1008);
        chk("pre_addr", imem.imem_addr, 64'h1008);
        ready_en = 1'b1;
        step(0, 1, 64'h3000);
        chk("rdi_req",  64'(imem.imem_req), 64'h0);
        chk("rdi_addr", imem.imem_addr,     64'h3000);
        step(0, 0, 0);
        chk("rdi_refetch", 64'(imem.imem_req), 64'h1);
        chk("rdi_valid",   64'(if_valid),      64'h0);
        step(0, 0, 0);
        step(0, 0, 0);
        chk("f5_valid", 64'(if_valid), 64'h1);
        chk("f5_if_pc", if_pc,         64'h3000);
        chk("f5_instr", 64'(if_instr), 64'hA5A5_3000);

        // Mixed latency, stall, back-pressure and redirect pattern (model-checked)
        for (int i = 0; i < 100; i++) begin
            logic        s;
            logic        r;
            logic [63:0] p;
            mem_lat  = i % 3;
            ready_en = (i % 4) != 1;
            s = ((i % 5) == 2) || ((i % 7) == 3) || (i >= 60 && i < 66);
            r = ((i % 13) == 6);
            p = (i == 45) ? 64'hFFFF_FFFF_FFFF_FFF9 : 64'h4000 + 64'(i * 16) + 64'(i % 4);
            step(s, r, p);
        end
        chk_en = 1'b0;

        // Wrap from the top of the address space, then async reset mid-wait
        @(negedge clk);
        rst1_n = 1'b1;
        @(posedge clk); #1;
        chk("w_req",  64'(imem1.imem_req), 64'h1);
        chk("w_addr", imem1.imem_addr,     64'hFFFF_FFFF_FFFF_FFFC);
        @(posedge clk); #1;
        imem1.imem_rvalid = 1'b1;
        imem1.imem_rdata  = 32'h0070_0113;
        @(posedge clk); #1;
        imem1.imem_rvalid = 1'b0;
        chk("w_valid", 64'(if_valid1),      64'h1);
        chk("w_if_pc", if_pc1,              64'hFFFF_FFFF_FFFF_FFFC);
        chk("w_instr", 64'(if_instr1),      64'h0070_0113);
        chk("w_next",  imem1.imem_addr,     64'h0);
        chk("w_req2",  64'(imem1.imem_req), 64'h1);
        @(posedge clk); #1;
        chk("w_wait", 64'(imem1.imem_req), 64'h0);
        rst1_n = 1'b0;
        #1;
        chk("ar_req",   64'(imem1.imem_req), 64'h0);
        chk("ar_valid", 64'(if_valid1),      64'h0);
        chk("ar_instr", 64'(if_instr1),      64'h13);
        chk("ar_if_pc", if_pc1,              64'h0);
        chk("ar_addr",  imem1.imem_addr,     64'hFFFF_FFFF_FFFF_FFFC);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
